// File: rtl/emu_dl_bank.sv
// Bank of set/clear-able D-latch channels emulated on a single clock, with
// sticky per-channel change flags and a registered readback port.
module emu_dl_bank #(
    parameter int               WIDTH   = 8,
    parameter int               CH      = 4,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}},
    localparam int              SELW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST,
    input  logic [CH-1:0]         i_SET,
    input  logic [CH-1:0]         i_CLR,
    input  logic [CH-1:0]         i_EN,
    input  logic [CH*WIDTH-1:0]   i_D,
    output logic [CH*WIDTH-1:0]   o_Q,
    input  logic [CH-1:0]         i_ACK,
    output logic [CH-1:0]         o_CHG,
    input  logic [SELW-1:0]       i_RDSEL,
    output logic [WIDTH-1:0]      o_RDQ,
    output logic                  o_RDVLD
);

    localparam logic [SELW:0] CH_LIM = (SELW+1)'(CH);

    // Packed so that channel n sits at [n*WIDTH +: WIDTH], matching i_D/o_Q.
    logic [CH-1:0][WIDTH-1:0] q_q;
    logic [CH-1:0][WIDTH-1:0] q_d;
    logic [CH-1:0]            chg_q;
    logic [CH-1:0]            chg_d;
    logic [WIDTH-1:0]         rdq_q;
    logic [WIDTH-1:0]         rdq_d;
    logic                     rdvld_q;
    logic                     rdvld_d;

    // Per-channel next value (reset > set > clear > enable > hold) and change flag.
    always_comb begin
        q_d   = q_q;
        chg_d = chg_q;
        for (int n = 0; n < CH; n++) begin
            if (i_RST) begin
                q_d[n] = {WIDTH{1'b0}};
            end else if (i_SET[n]) begin
                q_d[n] = SET_VAL;
            end else if (i_CLR[n]) begin
                q_d[n] = {WIDTH{1'b0}};
            end else if (i_EN[n]) begin
                q_d[n] = i_D[n*WIDTH +: WIDTH];
            end else begin
                q_d[n] = q_q[n];
            end

            // A fresh change beats a simultaneous acknowledge.
            if (i_RST) begin
                chg_d[n] = 1'b0;
            end else if (q_d[n] != q_q[n]) begin
                chg_d[n] = 1'b1;
            end else if (i_ACK[n]) begin
                chg_d[n] = 1'b0;
            end else begin
                chg_d[n] = chg_q[n];
            end
        end
    end

    // Readback samples the stored value before this edge's update.
    always_comb begin
        rdq_d   = {WIDTH{1'b0}};
        rdvld_d = 1'b0;
        if (i_RST) begin
            rdq_d   = {WIDTH{1'b0}};
            rdvld_d = 1'b0;
        end else begin
            rdvld_d = ({1'b0, i_RDSEL} < CH_LIM);
            for (int n = 0; n < CH; n++) begin
                if (i_RDSEL == SELW'(n)) begin
                    rdq_d = q_q[n];
                end else begin
                    rdq_d = rdq_d;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            q_q     <= '0;
            chg_q   <= {CH{1'b0}};
            rdq_q   <= {WIDTH{1'b0}};
            rdvld_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            chg_q   <= chg_d;
            rdq_q   <= rdq_d;
            rdvld_q <= rdvld_d;
        end
    end

    // Transparent mode exposes the next value so controls act within the cycle.
    always_comb begin
        if (MODE == 0) begin
            o_Q = q_d;
        end else begin
            o_Q = q_q;
        end
    end

    assign o_CHG   = chg_q;
    assign o_RDQ   = rdq_q;
    assign o_RDVLD = rdvld_q;

endmodule

// File: tb/tb_emu_dl_bank.sv
// Directed self-checking bench: registered (MODE 1) and transparent (MODE 0)
// 4-channel banks share stimulus; a 3-channel bank covers illegal readback selects.
module tb_emu_dl_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  set, clr, en, ack;
    logic [31:0] d;
    logic [1:0]  rdsel;
    logic [31:0] q0, q1;
    logic [3:0]  chg0, chg1;
    logic [7:0]  rdq0, rdq1;
    logic        rdvld0, rdvld1;

    logic [2:0]  set3, clr3, en3, ack3;
    logic [23:0] d3;
    logic [1:0]  rdsel3;
    logic [23:0] q3;
    logic [2:0]  chg3;
    logic [7:0]  rdq3;
    logic        rdvld3;

    int cmps = 0;
    int errs = 0;

    emu_dl_bank #(.WIDTH(8), .CH(4), .MODE(0)) u_m0 (
        .i_EMUCLK(clk), .i_RST(rst), .i_SET(set), .i_CLR(clr), .i_EN(en),
        .i_D(d), .o_Q(q0), .i_ACK(ack), .o_CHG(chg0), .i_RDSEL(rdsel),
        .o_RDQ(rdq0), .o_RDVLD(rdvld0)
    );

    emu_dl_bank #(.WIDTH(8), .CH(4), .MODE(1)) u_m1 (
        .i_EMUCLK(clk), .i_RST(rst), .i_SET(set), .i_CLR(clr), .i_EN(en),
        .i_D(d), .o_Q(q1), .i_ACK(ack), .o_CHG(chg1), .i_RDSEL(rdsel),
        .o_RDQ(rdq1), .o_RDVLD(rdvld1)
    );

    emu_dl_bank #(.WIDTH(8), .CH(3), .MODE(1)) u_c3 (
        .i_EMUCLK(clk), .i_RST(rst), .i_SET(set3), .i_CLR(clr3), .i_EN(en3),
        .i_D(d3), .o_Q(q3), .i_ACK(ack3), .o_CHG(chg3), .i_RDSEL(rdsel3),
        .o_RDQ(rdq3), .o_RDVLD(rdvld3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set = 4'h0; clr = 4'h0; en = 4'h0; ack = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set = 4'b1010; clr = 4'b0101; en = 4'hF; ack = 4'h3;
        d = 32'hDEADBEEF; rdsel = 2'd2;
        set3 = 3'b101; clr3 = 3'b010; en3 = 3'b111; ack3 = 3'b000;
        d3 = 24'h123456; rdsel3 = 2'd1;
        #1;
        cmps++; if (q0 !== 32'h0) begin errs++; $display("FAIL reset_m0_q_comb: got %h exp %h", q0, 32'h0); end
        tick(); tick();
        cmps++; if (q1 !== 32'h0) begin errs++; $display("FAIL reset_q: got %h exp %h", q1, 32'h0); end
        cmps++; if (chg1 !== 4'h0) begin errs++; $display("FAIL reset_chg: got %b exp %b", chg1, 4'h0); end
        cmps++; if (rdq1 !== 8'h00) begin errs++; $display("FAIL reset_rdq: got %h exp %h", rdq1, 8'h00); end
        cmps++; if (rdvld1 !== 1'b0) begin errs++; $display("FAIL reset_rdvld: got %b exp %b", rdvld1, 1'b0); end
        cmps++; if (q3 !== 24'h0) begin errs++; $display("FAIL reset_c3_q: got %h exp %h", q3, 24'h0); end
        cmps++; if (q0 !== 32'h0) begin errs++; $display("FAIL reset_m0_q: got %h exp %h", q0, 32'h0); end
        idle(); set3 = 3'b0; clr3 = 3'b0; en3 = 3'b0; ack3 = 3'b0;
        d = 32'h0; rdsel = 2'd0; d3 = 24'h0; rdsel3 = 2'd0;
        rst = 1'b0;
    endtask

    task automatic test_priority();
        set = 4'b0100; clr = 4'b0100; en = 4'b0100; d = 32'h005A0000;
        #1;
        cmps++; if (q0[23:16] !== 8'hFF) begin errs++; $display("FAIL prio_set_m0_comb: got %h exp %h", q0[23:16], 8'hFF); end
        tick();
        cmps++; if (q1[23:16] !== 8'hFF) begin errs++; $display("FAIL prio_set: got %h exp %h", q1[23:16], 8'hFF); end
        cmps++; if (chg1[2] !== 1'b1) begin errs++; $display("FAIL prio_set_chg: got %b exp %b", chg1[2], 1'b1); end
        set = 4'b0000;
        tick();
        cmps++; if (q1[23:16] !== 8'h00) begin errs++; $display("FAIL prio_clr: got %h exp %h", q1[23:16], 8'h00); end
        cmps++; if (chg1[2] !== 1'b1) begin errs++; $display("FAIL prio_clr_chg: got %b exp %b", chg1[2], 1'b1); end
        clr = 4'b0000;
        tick();
        cmps++; if (q1[23:16] !== 8'h5A) begin errs++; $display("FAIL prio_en: got %h exp %h", q1[23:16], 8'h5A); end
        cmps++; if (chg1 !== 4'b0100) begin errs++; $display("FAIL prio_en_chg: got %b exp %b", chg1, 4'b0100); end
        idle();
    endtask

    task automatic test_mode();
        en = 4'b0001; d = 32'h00000011;
        #1;
        cmps++; if (q0[7:0] !== 8'h11) begin errs++; $display("FAIL mode0_same_cycle_11: got %h exp %h", q0[7:0], 8'h11); end
        cmps++; if (q1[7:0] !== 8'h00) begin errs++; $display("FAIL mode1_lag_11: got %h exp %h", q1[7:0], 8'h00); end
        tick();
        cmps++; if (q1[7:0] !== 8'h11) begin errs++; $display("FAIL mode1_after_11: got %h exp %h", q1[7:0], 8'h11); end
        d = 32'h00000022;
        #1;
        cmps++; if (q0[7:0] !== 8'h22) begin errs++; $display("FAIL mode0_same_cycle_22: got %h exp %h", q0[7:0], 8'h22); end
        cmps++; if (q1[7:0] !== 8'h11) begin errs++; $display("FAIL mode1_lag_22: got %h exp %h", q1[7:0], 8'h11); end
        tick();
        cmps++; if (q1[7:0] !== 8'h22) begin errs++; $display("FAIL mode1_after_22: got %h exp %h", q1[7:0], 8'h22); end
        en = 4'b0000; d = 32'h00000099;
        #1;
        cmps++; if (q0[7:0] !== 8'h22) begin errs++; $display("FAIL mode0_hold: got %h exp %h", q0[7:0], 8'h22); end
        tick();
        cmps++; if (q0 !== 32'h005A0022) begin errs++; $display("FAIL mode0_hold_all: got %h exp %h", q0, 32'h005A0022); end
        cmps++; if (q1 !== 32'h005A0022) begin errs++; $display("FAIL mode1_hold_all: got %h exp %h", q1, 32'h005A0022); end
        idle();
    endtask

    task automatic test_chg();
        ack = 4'hF;
        tick();
        cmps++; if (chg1 !== 4'h0) begin errs++; $display("FAIL chg_ack_all: got %b exp %b", chg1, 4'h0); end
        ack = 4'h0; en = 4'b0010; d = 32'h00003300;
        tick();
        cmps++; if (chg1 !== 4'b0010) begin errs++; $display("FAIL chg_write33: got %b exp %b", chg1, 4'b0010); end
        ack = 4'b0010;
        tick();
        cmps++; if (chg1[1] !== 1'b0) begin errs++; $display("FAIL chg_rewrite_ack: got %b exp %b", chg1[1], 1'b0); end
        d = 32'h00004400;
        tick();
        cmps++; if (chg1[1] !== 1'b1) begin errs++; $display("FAIL chg_change_beats_ack: got %b exp %b", chg1[1], 1'b1); end
        cmps++; if (chg0[1] !== 1'b1) begin errs++; $display("FAIL chg_m0_change_beats_ack: got %b exp %b", chg0[1], 1'b1); end
        idle();
    endtask

    task automatic test_readback();
        logic [7:0] exp_b;
        en = 4'hF; d = 32'hA3A2A1A0;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            rdsel = 2'(i);
            exp_b = 8'hA0 + 8'(i);
            tick();
            cmps++; if (rdq1 !== exp_b) begin errs++; $display("FAIL rdq_ch%0d: got %h exp %h", i, rdq1, exp_b); end
            cmps++; if (rdvld1 !== 1'b1) begin errs++; $display("FAIL rdvld_ch%0d: got %b exp %b", i, rdvld1, 1'b1); end
        end
        en3 = 3'b111; d3 = 24'hC2C1C0;
        tick();
        en3 = 3'b000; rdsel3 = 2'd2;
        tick();
        cmps++; if (rdq3 !== 8'hC2) begin errs++; $display("FAIL rdq_c3_sel2: got %h exp %h", rdq3, 8'hC2); end
        cmps++; if (rdvld3 !== 1'b1) begin errs++; $display("FAIL rdvld_c3_sel2: got %b exp %b", rdvld3, 1'b1); end
        rdsel3 = 2'd3;
        tick();
        cmps++; if (rdq3 !== 8'h00) begin errs++; $display("FAIL rdq_c3_illegal: got %h exp %h", rdq3, 8'h00); end
        cmps++; if (rdvld3 !== 1'b0) begin errs++; $display("FAIL rdvld_c3_illegal: got %b exp %b", rdvld3, 1'b0); end
    endtask

    task automatic test_independence();
        en = 4'b1000; d = 32'h09000000;
        tick();
        idle(); ack = 4'hF;
        tick();
        cmps++; if (chg1 !== 4'h0) begin errs++; $display("FAIL indep_pre_chg: got %b exp %b", chg1, 4'h0); end
        ack = 4'h0; set = 4'b0001; clr = 4'b0010; en = 4'b0100; d = 32'h557E33CC;
        tick();
        cmps++; if (q1 !== 32'h097E00FF) begin errs++; $display("FAIL indep_q: got %h exp %h", q1, 32'h097E00FF); end
        cmps++; if (chg1 !== 4'b0111) begin errs++; $display("FAIL indep_chg: got %b exp %b", chg1, 4'b0111); end
        ack = 4'hF;
        tick();
        cmps++; if (q0 !== 32'h097E00FF) begin errs++; $display("FAIL indep_reload_q: got %h exp %h", q0, 32'h097E00FF); end
        cmps++; if (chg1 !== 4'b0000) begin errs++; $display("FAIL indep_reload_chg: got %b exp %b", chg1, 4'b0000); end
        idle();
    endtask

    task automatic test_mid_reset();
        set = 4'hF; rdsel = 2'd1; rst = 1'b1;
        #1;
        cmps++; if (q0 !== 32'h0) begin errs++; $display("FAIL midrst_m0_comb: got %h exp %h", q0, 32'h0); end
        tick();
        cmps++; if (q1 !== 32'h0) begin errs++; $display("FAIL midrst_q: got %h exp %h", q1, 32'h0); end
        cmps++; if (chg1 !== 4'h0) begin errs++; $display("FAIL midrst_chg: got %b exp %b", chg1, 4'h0); end
        cmps++; if (rdvld1 !== 1'b0) begin errs++; $display("FAIL midrst_rdvld: got %b exp %b", rdvld1, 1'b0); end
        rst = 1'b0; idle();
        tick();
        cmps++; if (q1 !== 32'h0) begin errs++; $display("FAIL midrst_after_q: got %h exp %h", q1, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_mode();
        test_chg();
        test_readback();
        test_independence();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/emu_dl_bank.md
# emu_dl_bank

Parametrised, clock-synchronous bank of set/clear-able D-latches for the emulation primitives library. It replaces discrete transparent latches with one block running on the emulation clock. It supports selectable transparent or registered output, per-channel set and clear, a sticky per-channel change flag with acknowledge, and a registered readback port. Control logic blocks instantiate it when they need several latched status or data fields that the CPU-side logic polls.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (1..32)
- CH, 4, number of channels (1..16)
- MODE, 0, 0 = transparent-latch emulation (o_Q follows i_D combinationally while enabled), 1 = registered (o_Q updates one clock after capture)
- SET_VAL, all ones, value loaded by i_SET (WIDTH bits)

Ports:
- i_EMUCLK  in  1  emulation clock; all state changes on its rising edge
- i_RST  in  1  synchronous active-high reset
- i_SET  in  CH  per-channel set; loads SET_VAL
- i_CLR  in  CH  per-channel clear; loads 0
- i_EN  in  CH  per-channel latch enable
- i_D  in  CH*WIDTH  channel n data at bits [n*WIDTH +: WIDTH]
- o_Q  out  CH*WIDTH  channel outputs, same packing as i_D
- i_ACK  in  CH  per-channel change-flag acknowledge
- o_CHG  out  CH  sticky change flags
- i_RDSEL  in  max(1,clog2(CH))  readback channel select
- o_RDQ  out  WIDTH  registered readback of the selected channel's stored value
- o_RDVLD  out  1  high when o_RDQ holds data for a legal i_RDSEL (i_RDSEL < CH)

## Operation
- Per channel stored register Q_s[n]. Next-value priority, evaluated per clock: i_RST → 0; else i_SET[n] → SET_VAL; else i_CLR[n] → 0; else i_EN[n] → i_D slice; else hold.
- MODE 0: o_Q[n] is combinational and equals the next-value expression, so set, clear and enable are visible in the same cycle, as a transparent latch would be. When all controls are low, o_Q[n] = Q_s[n].
- MODE 1: o_Q[n] = Q_s[n], with no combinational path from inputs.
- Change flag: o_CHG[n] sets on a clock where the next value of Q_s[n] differs from its current value. It clears on a clock with i_ACK[n] and no new change. If a change and i_ACK[n] occur in the same cycle, the change wins and the flag stays 1. Re-loading an identical value does not set the flag.
- Readback: on each clock, o_RDQ ← Q_s[i_RDSEL] (value before this edge's update) and o_RDVLD ← (i_RDSEL < CH). An illegal select loads o_RDQ = 0 and o_RDVLD = 0.
- Channels are fully independent. Any mix of set, clear and enable across channels in one cycle is legal.

## Timing
- Reset values: Q_s = 0, o_CHG = 0, o_RDQ = 0, o_RDVLD = 0. In MODE 1, o_Q = 0. In MODE 0, o_Q is forced to 0 while i_RST is high.
- Reset applied mid-operation overrides every other control on that edge. o_CHG does not set on the reset edge.
- MODE 0 latency from i_D to o_Q: 0 cycles while enabled. MODE 1 latency: 1 cycle.
- o_CHG asserts 1 cycle after the changing edge's inputs. i_ACK takes effect on the same edge.
- o_RDQ lags Q_s by 1 cycle: a value stored on edge k appears on o_RDQ after edge k+1 when selected.
- i_SET and i_CLR asserted together: set wins. Set or clear with i_EN asserted: i_D is ignored.

## Test plan
- Reset: WIDTH=8, CH=4, MODE 1. Drive inputs to arbitrary values, pulse i_RST for 2 cycles → o_Q=0, o_CHG=0, o_RDQ=0, o_RDVLD=0.
- Priority: on ch2 assert i_SET, i_CLR and i_EN together with D=0x5A → Q=0xFF. Next cycle, i_CLR plus i_EN with D=0x5A → Q=0x00. Next cycle, i_EN only with D=0x5A → Q=0x5A. o_CHG[2]=1 after each of these edges.
- Mode contrast: MODE 0, ch0 with i_EN high and D stepping 0x11→0x22 → o_Q follows in the same cycle, then holds 0x22 after EN drops. The same stimulus in MODE 1 shows o_Q lagging by 1 cycle.
- Change flag: write 0x33 to ch1 → o_CHG[1]=1. Rewrite 0x33 with ACK asserted → flag clears. Write 0x44 with ACK in the same cycle → flag stays 1.
- Readback: load channels with 0xA0..0xA3 and step i_RDSEL 0..3 → o_RDQ shows 0xA0..0xA3 one cycle later with o_RDVLD=1. With CH=3, i_RDSEL=3 → o_RDQ=0, o_RDVLD=0.
- Independence: in one cycle, set ch0, clear ch1, enable ch2 (D=0x7E), hold ch3 (=0x09) → 0xFF, 0x00, 0x7E, 0x09. o_CHG reflects only the channels whose value actually changed.
